// File: rtl/dma_pkg.sv
// Shared constants for the PCIe RX read path: completion descriptor offsets, TLP codes, FSM states.
// Latency: none (package only).
// Backpressure: n/a.
package dma_pkg;
    localparam int CMQ_ADDR_LO = 75;
    localparam int CMQ_PORT_LO = 57;
    localparam int CMQ_MEM_LO  = 53;
    localparam int CMQ_LEN_LO  = 43;
    localparam int CMQ_BC_LO   = 31;
    localparam int CMQ_RID_LO  = 15;
    localparam int CMQ_TAG_LO  = 7;
    localparam int CMQ_ADW_LO  = 2;

    localparam logic [4:0] TLP_TYPE_MRD   = 5'b00000;
    localparam logic [4:0] TLP_TYPE_MRDLK = 5'b00001;

    localparam int BAR0_IDX = 0;
    localparam int BAR2_IDX = 2;
    // The 4-bit memory field sits directly above the 2-bit if_select field.
    localparam int BAR_FLD_OFS = 2;
    localparam logic [3:0] BAR2_MEM_BASE = 4'd2;

    typedef enum logic [1:0] {
        ST_HDR1 = 2'd0,
        ST_HDR2 = 2'd1,
        ST_SKIP = 2'd2
    } rx_state_e;

    function automatic logic [3:0] bar_mem_sel(input logic bar0, input logic [3:0] fld);
        return bar0 ? fld : fld + BAR2_MEM_BASE;
    endfunction
endpackage

// File: rtl/pcie_byte_count.sv
// Completion byte count and lower address from the first/last byte enables and DW length.
// Latency: combinational.
// Backpressure: none.
module pcie_byte_count (
    input  logic [3:0]  first_be_i,
    input  logic [3:0]  last_be_i,
    input  logic [9:0]  len_i,
    output logic [11:0] byte_count_o,
    output logic [1:0]  low_addr_o
);
    logic [1:0] first_adj;
    logic [1:0] last_adj;

    always_comb begin
        casez (first_be_i)
            4'b???1: first_adj = 2'd0;
            4'b??10: first_adj = 2'd1;
            4'b?100: first_adj = 2'd2;
            4'b1000: first_adj = 2'd3;
            default: first_adj = 2'd0;
        endcase
        casez (last_be_i)
            4'b1???: last_adj = 2'd0;
            4'b01??: last_adj = 2'd1;
            4'b001?: last_adj = 2'd2;
            4'b0001: last_adj = 2'd3;
            default: last_adj = 2'd0;
        endcase
        low_addr_o = first_adj;
        if (last_be_i == 4'b0000) begin
            casez (first_be_i)
                4'b1??1:                   byte_count_o = 12'd4;
                4'b01?1, 4'b1?10:          byte_count_o = 12'd3;
                4'b0011, 4'b0110, 4'b1100: byte_count_o = 12'd2;
                default:                   byte_count_o = 12'd1;
            endcase
        end else begin
            // len 0 encodes 1024 DW; the 12-bit result wraps 4096 to 0 as the field requires.
            byte_count_o = {len_i, 2'b00} - {10'd0, first_adj} - {10'd0, last_adj};
        end
    end
endmodule

// File: rtl/pcie_rx_rd_mp.sv
// Decodes MRd TLPs from the TRN RX stream into one completion descriptor per read, steered to a per-port queue.
// Latency: write strobe and stats two clocks after the edge that samples header beat 2.
// Backpressure: almost-full queue drops the read (drop stat); trn_rnp_ok_n throttles the core when any queue is almost full.
module pcie_rx_rd_mp
    import dma_pkg::*;
#(
    parameter int NUM_PORTS     = 4,
    parameter int MEM_ADDR_BITS = 18,
    parameter int CM_Q_WIDTH    = 75 + MEM_ADDR_BITS,
    parameter int IF_SEL_LO     = 20
) (
    input  logic                  pcie_clk,
    input  logic                  rst,
    input  logic [63:0]           trn_rd,
    input  logic [7:0]            trn_rrem_n,
    input  logic                  trn_rsof_n,
    input  logic                  trn_reof_n,
    input  logic                  trn_rsrc_rdy_n,
    input  logic                  trn_rerrfwd_n,
    input  logic [6:0]            trn_rbar_hit_n,
    output logic                  trn_rnp_ok_n,
    output logic [NUM_PORTS-1:0]  cm_q_wr_en,
    output logic [CM_Q_WIDTH-1:0] cm_q_data,
    input  logic [NUM_PORTS-1:0]  cm_q_almost_full,
    output logic                  stat_pcie_rx_rd_cnt_inc,
    output logic                  stat_pcie_rx_rd_drop_inc,
    output logic                  stat_pcie_rx_rd_ur_inc
);
    localparam int BAR_LO  = IF_SEL_LO + BAR_FLD_OFS;
    localparam int ADDR_HI = BAR_LO + 3;

    logic [62:0] rd_q;
    logic        sof_q, eof_q, vld_q, err_q, bar0_q, bar2_q;
    logic [7:0]  rrem_unused_q;
    logic [5:0]  in_unused;
    assign in_unused = {trn_rd[63], trn_rbar_hit_n[6:3], trn_rbar_hit_n[1]};

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            rd_q          <= '0;
            sof_q         <= 1'b0;
            eof_q         <= 1'b0;
            vld_q         <= 1'b0;
            err_q         <= 1'b0;
            bar0_q        <= 1'b0;
            bar2_q        <= 1'b0;
            rrem_unused_q <= '0;
        end else begin
            rd_q          <= trn_rd[62:0];
            sof_q         <= ~trn_rsof_n;
            eof_q         <= ~trn_reof_n;
            vld_q         <= ~trn_rsrc_rdy_n;
            err_q         <= ~trn_rerrfwd_n;
            bar0_q        <= ~trn_rbar_hit_n[BAR0_IDX];
            bar2_q        <= ~trn_rbar_hit_n[BAR2_IDX];
            rrem_unused_q <= trn_rrem_n;
        end
    end

    rx_state_e state_q, state_d;
    logic      hdr_ld, req_ld;
    logic      h_4dw_q, h_rd_q, h_lk_q;
    logic [9:0]  h_len_q;
    logic [15:0] h_rid_q;
    logic [7:0]  h_tag_q;
    logic [3:0]  h_fbe_q, h_lbe_q;
    logic        hdr_is_rd, hdr_is_lk;
    logic [ADDR_HI:2] beat_addr;
    logic [3:0]  af_ext;

    assign hdr_is_rd = !rd_q[62] && (rd_q[60:56] == TLP_TYPE_MRD);
    assign hdr_is_lk = !rd_q[62] && (rd_q[60:56] == TLP_TYPE_MRDLK);
    assign beat_addr = h_4dw_q ? rd_q[ADDR_HI:2] : rd_q[32+ADDR_HI:34];
    assign af_ext    = 4'(cm_q_almost_full);

    always_comb begin
        state_d = state_q;
        hdr_ld  = 1'b0;
        req_ld  = 1'b0;
        case (state_q)
            ST_HDR1: if (vld_q && sof_q) begin
                if (!err_q) begin
                    hdr_ld  = 1'b1;
                    state_d = ST_HDR2;
                end else if (!eof_q) begin
                    state_d = ST_SKIP;
                end
            end
            ST_HDR2: if (vld_q) begin
                req_ld  = !err_q && (h_rd_q || h_lk_q);
                state_d = eof_q ? ST_HDR1 : ST_SKIP;
            end
            ST_SKIP: if (vld_q && eof_q) state_d = ST_HDR1;
            default: state_d = ST_HDR1;
        endcase
    end

    logic             req_vld_q, req_lk_q, req_hit0_q, req_hit2_q, req_af_q;
    logic [ADDR_HI:2] req_addr_q;

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            state_q    <= ST_HDR1;
            h_4dw_q    <= 1'b0;
            h_rd_q     <= 1'b0;
            h_lk_q     <= 1'b0;
            h_len_q    <= '0;
            h_rid_q    <= '0;
            h_tag_q    <= '0;
            h_fbe_q    <= '0;
            h_lbe_q    <= '0;
            req_vld_q  <= 1'b0;
            req_lk_q   <= 1'b0;
            req_hit0_q <= 1'b0;
            req_hit2_q <= 1'b0;
            req_af_q   <= 1'b0;
            req_addr_q <= '0;
        end else begin
            state_q   <= state_d;
            req_vld_q <= req_ld;
            if (hdr_ld) begin
                h_4dw_q <= rd_q[61];
                h_rd_q  <= hdr_is_rd;
                h_lk_q  <= hdr_is_lk;
                h_len_q <= rd_q[41:32];
                h_rid_q <= rd_q[31:16];
                h_tag_q <= rd_q[15:8];
                h_lbe_q <= rd_q[7:4];
                h_fbe_q <= rd_q[3:0];
            end
            if (req_ld) begin
                req_lk_q   <= h_lk_q;
                req_hit0_q <= bar0_q;
                req_hit2_q <= bar2_q;
                req_af_q   <= af_ext[beat_addr[IF_SEL_LO+1:IF_SEL_LO]];
                req_addr_q <= beat_addr;
            end
        end
    end

    logic [1:0]  req_port, low_addr;
    logic [3:0]  req_mem, wr_onehot;
    logic [11:0] byte_count;
    logic        port_ok, do_wr, do_drop, do_ur;
    logic [CM_Q_WIDTH-1:0] desc_d;

    pcie_byte_count u_byte_count (
        .first_be_i   (h_fbe_q),
        .last_be_i    (h_lbe_q),
        .len_i        (h_len_q),
        .byte_count_o (byte_count),
        .low_addr_o   (low_addr)
    );

    assign req_port  = req_addr_q[IF_SEL_LO+1:IF_SEL_LO];
    assign req_mem   = bar_mem_sel(req_hit0_q, req_addr_q[ADDR_HI:BAR_LO]);
    assign port_ok   = int'(req_port) < NUM_PORTS;
    assign wr_onehot = 4'b0001 << req_port;

    // Header regs stay valid here: a new head can only load on the same edge these results register.
    always_comb begin
        do_wr   = 1'b0;
        do_drop = 1'b0;
        do_ur   = 1'b0;
        if (req_vld_q) begin
            if (req_lk_q || !(req_hit0_q || req_hit2_q) || !port_ok) do_ur = 1'b1;
            else if (req_af_q) do_drop = 1'b1;
            else do_wr = 1'b1;
        end
        desc_d = '0;
        desc_d[CMQ_ADDR_LO +: MEM_ADDR_BITS] = req_addr_q[MEM_ADDR_BITS+1:2];
        desc_d[CMQ_PORT_LO +: 2]  = req_port;
        desc_d[CMQ_MEM_LO  +: 4]  = req_mem;
        desc_d[CMQ_LEN_LO  +: 10] = h_len_q;
        desc_d[CMQ_BC_LO   +: 12] = byte_count;
        desc_d[CMQ_RID_LO  +: 16] = h_rid_q;
        desc_d[CMQ_TAG_LO  +: 8]  = h_tag_q;
        desc_d[CMQ_ADW_LO  +: 5]  = req_addr_q[6:2];
        desc_d[1:0]               = low_addr;
    end

    always_ff @(posedge pcie_clk) begin
        if (rst) begin
            cm_q_wr_en               <= '0;
            cm_q_data                <= '0;
            stat_pcie_rx_rd_cnt_inc  <= 1'b0;
            stat_pcie_rx_rd_drop_inc <= 1'b0;
            stat_pcie_rx_rd_ur_inc   <= 1'b0;
            trn_rnp_ok_n             <= 1'b1;
        end else begin
            cm_q_wr_en               <= do_wr ? wr_onehot[NUM_PORTS-1:0] : '0;
            if (do_wr) cm_q_data     <= desc_d;
            stat_pcie_rx_rd_cnt_inc  <= do_wr;
            stat_pcie_rx_rd_drop_inc <= do_drop;
            stat_pcie_rx_rd_ur_inc   <= do_ur;
            trn_rnp_ok_n             <= |cm_q_almost_full;
        end
    end
endmodule
